// File: rtl/min_seq_sint16_pkg.sv
// Shared constants for the arithmetic lab min/max blocks: FSM encoding and
// default sample width / frame length.
package min_seq_sint16_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_COUNT = 3;

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

endpackage : min_seq_sint16_pkg

// File: rtl/min_seq_sint16_min2.sv
// Signed two-input minimum select; replace flags that b is strictly smaller.
// Latency: combinational.
// Backpressure: none (pure datapath).
module min2sint16 #(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] min,
    output logic                    replace
);

    // Strict compare so ties keep a, which holds the earlier sample.
    assign replace = (b < a);
    assign min     = replace ? b : a;

endmodule : min2sint16

// File: rtl/min_seq_sint16.sv
// Serial signed minimum + first-occurrence index over a COUNT-sample frame.
// Latency: out_valid rises the cycle after the last sample transfer.
// Backpressure: in_ready drops while a result is held; released the cycle after out handshake.
module min_seq_sint16
    import min_seq_sint16_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int COUNT = DEF_COUNT,
    parameter int IDXW  = (COUNT > 1) ? $clog2(COUNT) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_min,
    output logic [IDXW-1:0]         out_idx
);

    state_t                  state;
    state_t                  state_nxt;
    logic [IDXW-1:0]         cnt;
    logic signed [WIDTH-1:0] run_min;
    logic [IDXW-1:0]         run_idx;

    logic                    take;
    logic                    first;
    logic                    last;
    logic                    replace;
    logic signed [WIDTH-1:0] cmp_min;
    logic signed [WIDTH-1:0] sel_min;
    logic [IDXW-1:0]         sel_idx;

    assign in_ready = (state == ST_COLLECT);
    assign take     = in_valid && in_ready;
    assign first    = (cnt == '0);
    assign last     = (cnt == IDXW'(COUNT - 1));

    min2sint16 #(
        .WIDTH (WIDTH)
    ) u_min2 (
        .a       (run_min),
        .b       (in_data),
        .min     (cmp_min),
        .replace (replace)
    );

    // Min/idx including the sample currently offered; the first sample of a
    // frame loads unconditionally so stale running values never leak in.
    always_comb begin
        sel_min = cmp_min;
        sel_idx = run_idx;
        if (first) begin
            sel_min = in_data;
            sel_idx = '0;
        end else if (replace) begin
            sel_idx = cnt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_COLLECT: if (take && last)           state_nxt = ST_HOLD;
            ST_HOLD:    if (out_valid && out_ready) state_nxt = ST_COLLECT;
            default:                                state_nxt = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            run_min   <= '0;
            run_idx   <= '0;
            out_valid <= 1'b0;
            out_min   <= '0;
            out_idx   <= '0;
        end else begin
            if (take) begin
                if (last) begin
                    out_min   <= sel_min;
                    out_idx   <= sel_idx;
                    out_valid <= 1'b1;
                    cnt       <= '0;
                end else begin
                    run_min <= sel_min;
                    run_idx <= sel_idx;
                    cnt     <= cnt + IDXW'(1);
                end
            end
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule : min_seq_sint16

// File: tb/tb_min_seq_sint16.sv
// Directed bench for min_seq_sint16 (WIDTH=16, COUNT=3): table of frames plus
// hand-written backpressure, bubble and reset sequences.
module tb_min_seq_sint16;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_min;
    logic [1:0]         out_idx;

    int checks;
    int errors;

    typedef struct {
        string name;
        int    s0;
        int    s1;
        int    s2;
        int    emin;
        int    eidx;
    } vec_t;

    vec_t vecs[8];

    min_seq_sint16 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_min   (out_min),
        .out_idx   (out_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample and wait (bounded) until it is taken.
    task automatic send(input int d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = 16'(d);
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", 0, 1);
        end
        tick();
        in_valid = 1'b0;
        in_data  = 16'h5a5a;
    endtask

    // Full frame with out_ready held high, checking result timing and values.
    task automatic run_frame(input string name, input int s0, input int s1, input int s2,
                             input int emin, input int eidx);
        send(s0);
        send(s1);
        check({name, "_valid_early"}, int'(out_valid), 0);
        send(s2);
        check({name, "_valid"}, int'(out_valid), 1);
        check({name, "_min"}, int'(out_min), emin);
        check({name, "_idx"}, int'(out_idx), eidx);
        check({name, "_in_ready_hold"}, int'(in_ready), 0);
        tick();
        check({name, "_valid_clr"}, int'(out_valid), 0);
        check({name, "_in_ready_back"}, int'(in_ready), 1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        vecs[0] = '{"basic",    5,      -3,     7, -3,     1};
        vecs[1] = '{"extremes", 32767,  -32768, 0, -32768, 1};
        vecs[2] = '{"neg_first",-1,     1,      0, -1,     0};
        vecs[3] = '{"tie_all",  4,      4,      4, 4,      0};
        vecs[4] = '{"tie_late", 9,      2,      2, 2,      1};
        vecs[5] = '{"desc",     3,      2,      1, 1,      2};
        vecs[6] = '{"neg_last", -5,     -5,     -6, -6,    2};
        vecs[7] = '{"max_all",  32767,  32767,  32767, 32767, 0};

        tick();
        tick();
        reset = 1'b0;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_min", int'(out_min), 0);
        check("rst_out_idx", int'(out_idx), 0);
        check("rst_in_ready", int'(in_ready), 1);

        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i].name, vecs[i].s0, vecs[i].s1, vecs[i].s2,
                      vecs[i].emin, vecs[i].eidx);
        end

        // Backpressure: result must hold and no sample may be consumed.
        out_ready = 1'b0;
        send(8);
        send(-8);
        send(0);
        check("bp_valid", int'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = (i % 2 == 0) ? -16'sd30000 : 16'sd123;
            tick();
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_valid_hold", int'(out_valid), 1);
            check("bp_min_hold", int'(out_min), -8);
            check("bp_idx_hold", int'(out_idx), 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release", int'(out_valid), 0);
        run_frame("after_bp", 1, 2, 3, 1, 0);

        // Producer bubbles; invalid-cycle data must be ignored.
        begin
            int vpat[6] = '{1, 0, 0, 1, 0, 1};
            int dpat[6] = '{10, -999, -999, -20, -999, 30};
            for (int i = 0; i < 6; i++) begin
                in_valid = vpat[i][0];
                in_data  = 16'(dpat[i]);
                check("bubble_no_early", int'(out_valid), 0);
                tick();
            end
            in_valid = 1'b0;
            check("bubble_valid", int'(out_valid), 1);
            check("bubble_min", int'(out_min), -20);
            check("bubble_idx", int'(out_idx), 1);
            tick();
            check("bubble_clr", int'(out_valid), 0);
        end

        // Reset mid-frame discards the partial frame.
        send(-100);
        send(-200);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        run_frame("post_midrst", 1, 2, 3, 1, 0);

        // Reset during HOLD drops the pending result.
        out_ready = 1'b0;
        send(-7);
        send(-8);
        send(-9);
        check("holdrst_pre_valid", int'(out_valid), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        check("holdrst_valid", int'(out_valid), 0);
        check("holdrst_min", int'(out_min), 0);
        check("holdrst_idx", int'(out_idx), 0);
        check("holdrst_in_ready", int'(in_ready), 1);
        run_frame("post_holdrst", 6, 5, 6, 5, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_min_seq_sint16

// File: doc/min_seq_sint16.md
Name: min_seq_sint16

Overview:
- Serial signed-minimum finder for the arithmetic lab datapath; the min-direction, streaming counterpart of the three-input combinational signed maximum block.
- Accepts a frame of COUNT signed samples, one per valid/ready transfer.
- Returns the frame minimum and the index of its first occurrence through a valid/ready output port.
- Sits between a sample producer (switch/register source) and a result consumer (display or downstream compare stage).

Parameters:
- WIDTH, 16, sample width in bits; two's-complement signed.
- COUNT, 3, samples per frame; must be >= 1.
- IDXW, $clog2(COUNT) with a floor of 1, width of the index output.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer presents a sample.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  WIDTH  signed sample.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_min  output  WIDTH  signed minimum of the frame.
- out_idx  output  IDXW  zero-based index of the first occurrence of the minimum.

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset values: state=COLLECT, sample counter=0, running min=0, running idx=0, out_valid=0, out_min=0, out_idx=0.
- in_ready is combinational: it equals (state==COLLECT), so it reads 1 in the first cycle after reset deasserts.
- A transfer occurs in any cycle where in_valid and in_ready are both 1. No transfer occurs when in_valid=0; state holds.
- COLLECT, accepted sample k (k = counter value):
  - k==0: load running min=in_data and running idx=0 unconditionally.
  - k>0: replace min/idx only if in_data < running min, using a signed comparison. Ties keep the earlier index.
  - k==COUNT-1: instead of storing into the running registers, write the final min/idx (including the current sample) into out_min/out_idx, set out_valid=1, clear the counter, and go to HOLD. Otherwise increment the counter.
- HOLD:
  - in_ready=0.
  - out_valid, out_min and out_idx stay stable until out_valid && out_ready.
  - On that handshake: out_valid=0 next cycle, state=COLLECT.
  - out_min/out_idx keep their last values; they are don't-care while out_valid=0, but must not change while it is 1.
- Latency: out_valid rises the cycle after the last sample transfer.
- Throughput: with in_valid and out_ready held high, one frame per COUNT+1 cycles. There is no same-cycle bypass from the output handshake to in_ready.
- Width rules:
  - All compares are signed WIDTH-bit; there is no arithmetic, so overflow is not possible.
  - -32768 < 32767 must hold for WIDTH=16.
- COUNT=1: every accepted sample goes straight to HOLD with out_idx=0.
- Reset mid-frame or during HOLD: the partial frame or pending result is discarded, all registers return to reset values, and no output handshake occurs.
- in_valid asserted during HOLD is ignored (in_ready=0). in_data must not be sampled.

Decomposition:
- Shared header/package: state encoding localparams (ST_COLLECT=0, ST_HOLD=1) and the default WIDTH/COUNT constants reused by the lab's min/max blocks.
- One natural sub-module: min2sint16, a combinational signed two-input select that outputs the smaller value and a "replace" flag (b < a). It is instantiated once for the running compare.
- FSM, counter and output registers stay in the top module.

Test Plan:
- Reset then frame {5, -3, 7} with out_ready=1 -> out_valid one cycle after the third transfer; out_min=-3, out_idx=1; next frame accepted 1 cycle after the handshake.
- Signed extremes {32767, -32768, 0} -> out_min=-32768 (0x8000), out_idx=1. Also {-1, 1, 0} -> out_min=-1, out_idx=0.
- Ties {4, 4, 4} -> out_min=4, out_idx=0. {9, 2, 2} -> out_min=2, out_idx=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid rises, with in_valid=1 and in_data toggling -> in_ready=0, outputs constant, no sample consumed; releasing out_ready completes one handshake.
- Producer bubbles: in_valid pattern 1,0,0,1,0,1 with samples {10, -20, 30} -> result out_min=-20, out_idx=1 only after the third transfer.
- Reset mid-frame after 2 samples {-100, -200}, then frame {1, 2, 3} -> out_min=1, out_idx=0; no stale -200 appears.
